burst_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready downstream data channel between `NUM_REQ` burst masters. The arbiter locks a grant for a full burst of `BURST_LEN` beats and releases it only after the last beat handshakes. It sits between the per-source masters and the single consumer on the handshake bus. It marks the final beat of each burst and exposes the current grant for debug and bench checking.

---
 rtl/burst_arbiter.sv | 114 +++++++++++
 tb/tb_burst_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_arbiter.sv
// rtl/burst_arbiter.sv - round-robin arbiter locking one valid/ready channel per burst
module burst_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 3
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dn_valid,
  output logic [DATA_W-1:0]         dn_data,
  output logic                      dn_last,
  input  logic                      dn_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   gidx;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     scan;
  logic               hs;

  // Scan requesters starting just after the previous owner; first valid one wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, last_idx} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ)) begin
        scan = scan - (IDX_W+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[scan[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IDX_W-1:0];
      end
    end
  end

  // Encode the one-hot grant into an index for muxing the data path.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx = IDX_W'(i);
      end
    end
  end

  // Combinational data path from the owner to the consumer; forced quiet in reset and idle.
  always_comb begin
    dn_valid  = 1'b0;
    dn_data   = '0;
    dn_last   = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    if (!sys_rst && state == BURST) begin
      busy            = 1'b1;
      dn_valid        = req_valid[gidx];
      req_ready[gidx] = dn_ready;
      if (dn_valid) begin
        dn_data = req_data[gidx*DATA_W +: DATA_W];
      end
      dn_last = dn_valid && (beat_cnt == LAST_BEAT);
    end
  end

  assign hs = dn_valid & dn_ready;

  // Arbitration and burst-lock FSM; grant is held until the last beat handshakes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BURST;
            grant    <= NUM_REQ'(1) << pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (hs) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              grant    <= '0;
              beat_cnt <= '0;
              last_idx <= gidx;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_arbiter.sv
// tb/tb_burst_arbiter.sv - self-checking bench for burst_arbiter
module tb_burst_arbiter;
  localparam int N = 2;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic           dn_ready = 1'b1;
  logic [N-1:0]   req_ready, grant, req_ready1, grant1;
  logic           dn_valid, dn_last, busy, dn_valid1, dn_last1, busy1;
  logic [W-1:0]   dn_data, dn_data1;

  burst_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(3)) u_dut (
    .sys_clk(clk), .sys_rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dn_valid(dn_valid), .dn_data(dn_data), .dn_last(dn_last),
    .dn_ready(dn_ready), .grant(grant), .busy(busy));

  burst_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready1), .dn_valid(dn_valid1), .dn_data(dn_data1), .dn_last(dn_last1),
    .dn_ready(dn_ready), .grant(grant1), .busy(busy1));

  typedef struct {int m; logic [W-1:0] d; logic last;} beat_t;
  beat_t exp_q[$];
  beat_t e;

  logic [W-1:0] src[N][8];
  int           src_ptr[N];
  int           src_len[N];
  logic         use1 = 1'b0;
  logic [N-1:0] hs_cap;
  int           n_cmp = 0;
  int           n_fail = 0;

  function automatic logic has(int m);
    return src_ptr[m] < src_len[m];
  endfunction

  task automatic load(int m, logic [W-1:0] d);
    src[m][src_len[m]] = d;
    src_len[m]++;
  endtask

  task automatic push_exp(int m, int first, int cnt);
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back('{m: m, d: src[m][first+k], last: (k == cnt-1)});
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_ptr[i] = 0;
      src_len[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = has(i) ? src[i][src_ptr[i]] : '0;
    end
  endtask

  task automatic capture();
    @(negedge clk);
    hs_cap = req_valid & (use1 ? req_ready1 : req_ready);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs_cap[i]) src_ptr[i]++;
    end
    #1;
    drive_data();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    dn_ready = 1'b1;
    clear_src();
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if ({grant, busy, dn_valid, dn_last, req_ready, dn_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got grant=%b busy=%b dn_valid=%b req_ready=%b want all 0", grant, busy, dn_valid, req_ready);
    end
    n_cmp++;
    if ({grant1, busy1, dn_valid1, req_ready1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_bl1 got grant=%b busy=%b want 0", grant1, busy1);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({grant, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle got grant=%b busy=%b want 00 0", grant, busy);
    end
  endtask

  task automatic test_single_burst();
    logic [N-1:0] exp_g;
    do_reset();
    load(0, 3'b111); load(0, 3'b101); load(0, 3'b110);
    push_exp(0, 0, 3);
    for (int c = 0; c <= 4; c++) begin
      req_valid = {1'b0, has(0)};
      drive_data();
      capture();
      exp_g = (c >= 1 && c <= 3) ? 2'b01 : 2'b00;
      n_cmp++;
      if (grant !== exp_g || dn_last !== (c == 3)) begin
        n_fail++;
        $display("FAIL single_cycle%0d got grant=%b last=%b want grant=%b last=%b", c, grant, dn_last, exp_g, (c == 3));
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL single_beat got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data, dn_last} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL single_beat got g=%b d=%b l=%b want g=%b d=%b l=%b", grant, dn_data, dn_last, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    for (int k = 0; k < 6; k++) load(0, W'(k + 1));
    load(1, 3'd7); load(1, 3'd0); load(1, 3'd3); load(1, 3'd4); load(1, 3'd2); load(1, 3'd5);
    push_exp(0, 0, 3); push_exp(1, 0, 3); push_exp(0, 3, 3); push_exp(1, 3, 3);
    for (int c = 0; c <= 16; c++) begin
      req_valid = {has(1), has(0)};
      drive_data();
      capture();
      exp_g = (c % 4 == 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (grant !== exp_g || busy !== (exp_g != 0)) begin
        n_fail++;
        $display("FAIL rr_cycle%0d got grant=%b busy=%b want grant=%b", c, grant, busy, exp_g);
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_beat got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data, dn_last} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL rr_beat got g=%b d=%b l=%b want g=%b d=%b l=%b", grant, dn_data, dn_last, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_g;
    do_reset();
    load(0, 3'b111); load(0, 3'b101); load(0, 3'b110);
    push_exp(0, 0, 3);
    for (int c = 0; c <= 5; c++) begin
      req_valid = {1'b0, has(0)};
      dn_ready = (c != 2);
      drive_data();
      capture();
      exp_g = (c >= 1 && c <= 4) ? 2'b01 : 2'b00;
      n_cmp++;
      if (grant !== exp_g || dn_last !== (c == 4)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d got grant=%b last=%b want grant=%b last=%b", c, grant, dn_last, exp_g, (c == 4));
      end
      if (c == 2) begin
        n_cmp++;
        if ({dn_valid, dn_data, req_ready} !== {1'b1, 3'b101, 2'b00}) begin
          n_fail++;
          $display("FAIL bp_hold got v=%b d=%b rdy=%b want v=1 d=101 rdy=00", dn_valid, dn_data, req_ready);
        end
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_beat got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data, dn_last} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL bp_beat got g=%b d=%b l=%b want g=%b d=%b l=%b", grant, dn_data, dn_last, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    dn_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_source_stall();
    logic [N-1:0] exp_g;
    do_reset();
    load(1, 3'd3); load(1, 3'd6); load(1, 3'd1);
    load(0, 3'd2); load(0, 3'd4); load(0, 3'd5);
    push_exp(1, 0, 3); push_exp(0, 0, 3);
    for (int c = 0; c <= 10; c++) begin
      req_valid[1] = has(1) && !(c == 2 || c == 3);
      req_valid[0] = has(0) && (c >= 1);
      drive_data();
      capture();
      exp_g = (c >= 1 && c <= 5) ? 2'b10 : ((c >= 7 && c <= 9) ? 2'b01 : 2'b00);
      n_cmp++;
      if (grant !== exp_g || dn_last !== (c == 5 || c == 9)) begin
        n_fail++;
        $display("FAIL stall_cycle%0d got grant=%b last=%b want grant=%b", c, grant, dn_last, exp_g);
      end
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (dn_valid !== 1'b0 || u_dut.beat_cnt !== 2'd1) begin
          n_fail++;
          $display("FAIL stall_hold got v=%b cnt=%0d want v=0 cnt=1", dn_valid, u_dut.beat_cnt);
        end
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_beat got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data, dn_last} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL stall_beat got g=%b d=%b l=%b want g=%b d=%b l=%b", grant, dn_data, dn_last, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [N-1:0] exp_g;
    do_reset();
    load(1, 3'd1); load(1, 3'd2); load(1, 3'd3);
    push_exp(1, 0, 1);
    for (int c = 0; c <= 1; c++) begin
      req_valid = {has(1), 1'b0};
      drive_data();
      capture();
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rstmid_beat got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data} !== {N'(1 << e.m), e.d}) begin
            n_fail++;
            $display("FAIL rstmid_beat got g=%b d=%b want g=%b d=%b", grant, dn_data, N'(1 << e.m), e.d);
          end
        end
      end
      advance();
    end
    req_valid = 2'b11;
    drive_data();
    #1;
    n_cmp++;
    if ({grant, dn_valid, dn_data} !== {2'b10, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL rstmid_before got g=%b v=%b d=%b want g=10 v=1 d=010", grant, dn_valid, dn_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, busy, dn_valid, dn_last, req_ready, dn_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got g=%b busy=%b v=%b rdy=%b d=%b want all 0", grant, busy, dn_valid, req_ready, dn_data);
    end
    clear_src();
    load(0, 3'd6); load(0, 3'd3); load(0, 3'd5);
    load(1, 3'd4); load(1, 3'd7); load(1, 3'd1);
    push_exp(0, 0, 3); push_exp(1, 0, 3);
    drive_data();
    @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_held got grant=%b want 00", grant);
    end
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      req_valid = {has(1), has(0)};
      drive_data();
      capture();
      exp_g = (c >= 1 && c <= 3) ? 2'b01 : ((c >= 5 && c <= 7) ? 2'b10 : 2'b00);
      n_cmp++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL rstmid_cycle%0d got grant=%b want %b", c, grant, exp_g);
      end
      if (dn_valid && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rstmid_after got unexpected data=%b want none", dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, dn_data, dn_last} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL rstmid_after got g=%b d=%b l=%b want g=%b d=%b l=%b", grant, dn_data, dn_last, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_drain got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_burst_len1();
    logic [N-1:0] exp_g;
    use1 = 1'b1;
    do_reset();
    load(0, 3'd5); load(0, 3'd2);
    load(1, 3'd6); load(1, 3'd1);
    push_exp(0, 0, 1); push_exp(1, 0, 1); push_exp(0, 1, 1); push_exp(1, 1, 1);
    for (int c = 0; c <= 8; c++) begin
      req_valid = {has(1), has(0)};
      drive_data();
      capture();
      exp_g = (c % 2 == 0) ? 2'b00 : ((((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (grant1 !== exp_g || dn_last1 !== (c % 2 == 1)) begin
        n_fail++;
        $display("FAIL bl1_cycle%0d got grant=%b last=%b want grant=%b last=%b", c, grant1, dn_last1, exp_g, (c % 2 == 1));
      end
      if (dn_valid1 && dn_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bl1_beat got unexpected data=%b want none", dn_data1);
        end else begin
          e = exp_q.pop_front();
          if ({grant1, dn_data1, dn_last1} !== {N'(1 << e.m), e.d, e.last}) begin
            n_fail++;
            $display("FAIL bl1_beat got g=%b d=%b l=%b want g=%b d=%b l=%b", grant1, dn_data1, dn_last1, N'(1 << e.m), e.d, e.last);
          end
        end
      end
      advance();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bl1_drain got %0d beats left want 0", exp_q.size());
    end
    use1 = 1'b0;
  endtask

  initial begin
    clear_src();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_source_stall();
    test_reset_mid_burst();
    test_burst_len1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
